skip_add_accumulator: RTL
=========================

# skip_add_accumulator

Streaming accumulator built around the 32-bit carry-skip adder (`carryskip32_bit`). It sits directly downstream of the adder and consumes its `sum`/`cout` every cycle. It accepts a packet of 32-bit operands over a valid/ready handshake and folds each operand into a running total: the low 32 bits come from the adder and the carry-out extends the upper bits. At the end of each packet it presents the extended sum, the beat count and an overflow flag on an output handshake.

## Interface

Parameters:
- `EXT_W`, 8: number of carry-extension bits above the 32-bit adder result; `out_sum` is `32+EXT_W` bits wide.
- `CNT_W`, 16: width of the beat counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `in_valid`, in, 1: operand beat valid.
- `in_ready`, out, 1: block can accept a beat.
- `in_data`, in, 32: operand.
- `in_last`, in, 1: final beat of the packet; qualified by the `in_valid && in_ready` handshake.
- `out_valid`, out, 1: packet result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_sum`, out, 32+EXT_W: accumulated sum, modulo 2^(32+EXT_W).
- `out_count`, out, CNT_W: number of beats in the packet, including the last beat; saturating.
- `out_overflow`, out, 1: sticky flag, set when the extension field wrapped during the packet.

## Operation

- **Datapath:** one `carryskip32_bit` instance, with `a = acc_lo`, `b = in_data`, `cin = 0`.
- **Beat update:** on each accepted beat:
  - `acc_lo <= sum`.
  - `acc_hi <= acc_hi + cout`, modulo 2^EXT_W.
  - `cnt <= cnt + 1`, saturating at 2^CNT_W-1.
  - `ovf <= ovf | (cout && acc_hi == all-ones)`.
- **State machine:** two states, ACC and OUT. `in_ready = (state == ACC)` and `out_valid = (state == OUT)`; both are decoded from the registered state only.
- **ACC state:**
  - Every cycle with `in_valid = 1` is an accepted beat.
  - If the accepted beat has `in_last = 1`, load the output registers with the updated values (that beat included), clear the accumulators, and go to OUT.
  - Otherwise remain in ACC.
  - `in_valid = 0` leaves the state and the accumulators unchanged.
- **OUT state:**
  - `out_sum = {ov_hi, ov_lo}`, `out_count` and `out_overflow` are driven from output registers and held stable while `out_ready = 0`.
  - On `out_ready = 1`, return to ACC.
  - The output registers are not cleared, but they are don't-care once `out_valid = 0`.
- **Accumulator clearing:** the accumulators are cleared on the same edge that loads the output registers. A new packet can therefore begin on the first cycle after OUT is exited.
- **Empty packets:** packets with zero beats are impossible; a packet always contains at least its `in_last` beat.
- **Reset** (`rst_n = 0` at an edge):
  - state = ACC.
  - `acc_lo`, `acc_hi`, `cnt`, `ovf` and all output registers = 0.
  - Resulting outputs: `in_ready = 1`, `out_valid = 0`, `out_sum = 0`, `out_count = 0`, `out_overflow = 0`.
  - Reset mid-packet discards the partial sum. Reset during OUT drops the pending result without a handshake.
- **Precedence:** reset overrides every other event.

## Timing

- **Throughput:** one beat per cycle within a packet.
- **Packet overhead:** at least one idle input cycle per packet (the OUT cycle), plus one cycle for every cycle `out_ready` is held low.
- **Latency:** `out_valid` rises on the clock edge that accepts the `in_last` beat, so the result is visible in the following cycle.
- **Handshakes:** standard valid/ready. Data transfers when valid and ready are both high at an edge.
- **Input side:**
  - `in_valid` must not depend on `in_ready`.
  - `in_ready` has no combinational path from any input.
- **Output side:**
  - `out_valid`, once high, stays high until it is accepted.
  - `out_*` are constant while `out_valid && !out_ready`.
- **Critical path:** the `acc_lo` register through the 32-bit carry-skip chain (8 skip blocks) into the `acc_hi` incrementer and the overflow logic. This must close in a single cycle; no pipelining inside the adder.

## Test plan

1. **Basic packet:** reset, then beats 1, 2, 3 (`in_last` on 3) with `out_ready = 1` → one cycle later `out_sum = 0x00_0000_0006`, `out_count = 3`, `out_overflow = 0`; `in_ready = 1` again the following cycle.
2. **Carry into extension:** beats `0xFFFFFFFF`, then `0x00000001` with `in_last` → `out_sum = 0x01_0000_0000`, `out_count = 2`.
3. **Extension wrap (EXT_W = 8):** 257 beats of `0xFFFFFFFF`, with `in_last` on the 257th → `out_sum = 0x00_FFFF_FEFF`, `out_count = 257`, `out_overflow = 1`.
4. **Backpressure:** single beat `0xDEADBEEF` with `in_last`, then `out_ready = 0` for 5 cycles while `in_valid = 1` with the next packet → `in_ready = 0`, `out_sum = 0x00_DEAD_BEEF` and `out_count = 1` stable. On `out_ready = 1`, `in_ready = 1` on the next cycle and the next packet starts from 0.
5. **Idle gaps:** beats 10, (`in_valid` low for 3 cycles), 20 with `in_last` → `out_sum = 30`, `out_count = 2`.
6. **Reset mid-packet:** beats 5, 7, then `rst_n = 0` for one cycle, then beat 9 with `in_last` → `out_sum = 9`, `out_count = 1`, `out_overflow = 0`. Also check that all outputs are 0 and `in_ready = 1` in the cycle right after reset.

Source files
------------

// File: rtl/skip_add_accumulator.sv
// Packet accumulator: folds 32-bit beats into a running sum whose carries grow
// an EXT_W-bit extension field; each packet's result is held on an output handshake.

// Purpose: 32-bit carry-skip adder, 8 blocks of 4-bit ripple with block bypass.
// Latency: combinational.
// Backpressure: none (pure datapath).
module carryskip32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [8:0] blk_c;
  logic [7:0] blk_p;
  logic       rc;
  logic       p;

  // A block whose bits all propagate forwards its carry-in directly,
  // so the worst path skips over the interior ripple of middle blocks.
  always_comb begin
    sum      = '0;
    blk_c    = '0;
    blk_p    = '0;
    rc       = 1'b0;
    p        = 1'b0;
    blk_c[0] = cin;
    for (int g = 0; g < 8; g++) begin
      rc       = blk_c[g];
      blk_p[g] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        p              = a[4*g+i] ^ b[4*g+i];
        sum[4*g+i]     = p ^ rc;
        rc             = (a[4*g+i] & b[4*g+i]) | (p & rc);
        blk_p[g]       = blk_p[g] & p;
      end
      blk_c[g+1] = blk_p[g] ? blk_c[g] : rc;
    end
    cout = blk_c[8];
  end

endmodule

// Purpose: per-packet sum/count/overflow accumulator around carryskip32_bit.
// Latency: result valid the cycle after the in_last beat is accepted.
// Backpressure: in_ready low while a result waits; out_* held until out_ready.
module skip_add_accumulator #(
  parameter int EXT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32+EXT_W-1:0] out_sum,
  output logic [CNT_W-1:0]    out_count,
  output logic                out_overflow
);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  typedef struct packed {
    logic [EXT_W-1:0] hi;
    logic [31:0]      lo;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } res_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      acc_lo;
  logic [EXT_W-1:0] acc_hi;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  res_t             res_q;
  res_t             res_nxt;

  logic [31:0]      add_sum;
  logic             add_cout;
  logic             beat;

  carryskip32_bit u_add (
    .a    (acc_lo),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign beat      = in_valid && (state == ACC);

  // Running values with the current beat folded in.
  always_comb begin
    res_nxt     = '0;
    res_nxt.lo  = add_sum;
    res_nxt.hi  = acc_hi + {{(EXT_W-1){1'b0}}, add_cout};
    res_nxt.cnt = (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    res_nxt.ovf = ovf | (add_cout & (&acc_hi));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (beat && in_last) state_nxt = OUT;
      OUT:     if (out_ready)       state_nxt = ACC;
      default:                      state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ACC;
      acc_lo <= '0;
      acc_hi <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      res_q  <= '0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        if (in_last) begin
          res_q  <= res_nxt;
          acc_lo <= '0;
          acc_hi <= '0;
          cnt    <= '0;
          ovf    <= 1'b0;
        end else begin
          acc_lo <= res_nxt.lo;
          acc_hi <= res_nxt.hi;
          cnt    <= res_nxt.cnt;
          ovf    <= res_nxt.ovf;
        end
      end
    end
  end

  assign out_sum      = {res_q.hi, res_q.lo};
  assign out_count    = res_q.cnt;
  assign out_overflow = res_q.ovf;

endmodule
